// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: in-order instruction prefetch queue between imem and IF/ID with redirect discard.
// Optional PFQ_BYPASS_EN forwards a response straight to the output when the queue is empty.
module if_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  input  logic        out_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic {FETCH, DRAIN} state_t;
  state_t state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, target;
  logic [CW-1:0] count_q, count_d, outst_q, outst_d, discard_q, discard_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW:0] inflight;
  logic [31:0] inst_mem [DEPTH];
  logic [31:0] pc_mem [DEPTH];
  logic resp, drop, accept, stored, byp, push, pop;
  always_comb begin
    inflight  = {1'b0, count_q} + {1'b0, outst_q};
    imem_req  = rst && state_q == FETCH && !redirect && inflight < (CW+1)'(DEPTH);
    imem_addr = fetch_pc_q;
    target    = redirect_pc & ~32'h3;
    // responses with nothing outstanding are protocol violations and ignored
    resp      = imem_valid && outst_q != '0;
    drop      = resp && discard_q != '0;
    accept    = resp && discard_q == '0;
    stored    = count_q != '0;
`ifdef PFQ_BYPASS_EN
    byp       = accept && !stored && !redirect;
`else
    byp       = 1'b0;
`endif
    out_valid = stored || byp;
    out_inst  = stored ? inst_mem[rd_ptr_q] : byp ? imem_rdata : '0;
    out_pc    = stored ? pc_mem[rd_ptr_q] : byp ? resp_pc_q + 32'd4 : '0;
    push      = accept && !redirect && !(byp && out_ready);
    pop       = stored && out_ready && !redirect;
    // the response landing in the redirect cycle is already stale, so it leaves discard too
    fetch_pc_d = redirect ? target : fetch_pc_q + (imem_req ? 32'd4 : 32'd0);
    resp_pc_d  = redirect ? target : resp_pc_q + (accept ? 32'd4 : 32'd0);
    count_d    = redirect ? '0 : count_q + CW'(push) - CW'(pop);
    rd_ptr_d   = redirect ? '0 : rd_ptr_q + AW'(pop);
    wr_ptr_d   = redirect ? '0 : wr_ptr_q + AW'(push);
    outst_d    = outst_q + CW'(imem_req) - CW'(resp);
    discard_d  = redirect ? outst_q - CW'(resp) : discard_q - CW'(drop);
    state_d    = discard_d != '0 ? DRAIN : FETCH;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      count_q    <= '0;
      outst_q    <= '0;
      discard_q  <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr_q] <= imem_rdata;
      pc_mem[wr_ptr_q]   <= resp_pc_q + 32'd4;
    end
  end
endmodule

// File: tb/tb_if_prefetch_queue.sv
// tb_if_prefetch_queue: scoreboard bench with an in-order latency memory model for if_prefetch_queue.
module tb_if_prefetch_queue;
  localparam int DEPTH = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
`ifdef PFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic imem_req, imem_valid = 1'b0, out_valid, out_ready = 1'b0, redirect = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0, out_inst, out_pc, redirect_pc = '0;

  if_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata), .out_valid(out_valid),
    .out_inst(out_inst), .out_pc(out_pc), .out_ready(out_ready),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  int passed = 0, total = 0;
  int cyc = 0, lat = 1, n_req = 0, n_pop = 0, watch_cyc = 0;
  bit req_now, vld_now, deliv, watch = 1'b0;
  logic [31:0] addr_now, pc_now, watch_addr;
  logic [31:0] pa[$];
  int pd[$];
  logic [63:0] exp_q[$];

  function automatic logic [31:0] f(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic new_flow(input logic [31:0] base);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back({f(base + 32'(4*i)), base + 32'(4*i + 4)});
  endtask

  // one clock: memory drives its due response, then outputs are sampled mid-cycle
  task automatic cycle();
    logic [31:0] ta, tgt;
    logic [63:0] e;
    int td;
    deliv = pd.size() > 0 && pd[0] <= cyc;
    imem_valid = deliv;
    imem_rdata = deliv ? f(pa[0]) : '0;
    if (deliv) begin
      ta = pa.pop_front();
      td = pd.pop_front();
    end
    #1;
    req_now = imem_req; addr_now = imem_addr; vld_now = out_valid; pc_now = out_pc;
    if (redirect) begin
      total++;
      if (imem_req !== 1'b0) $display("FAIL redirect_no_req: got %b expected 0", imem_req); else passed++;
    end else if (req_now) begin
      pa.push_back(addr_now);
      pd.push_back(cyc + lat);
      n_req++;
      if (watch) begin
        total += 2;
        if (cyc !== watch_cyc) $display("FAIL resume_cycle: got %0d expected %0d", cyc, watch_cyc); else passed++;
        if (addr_now !== watch_addr) $display("FAIL resume_addr: got %h expected %h", addr_now, watch_addr); else passed++;
        watch = 1'b0;
      end
    end
    if (!vld_now) begin
      total++;
      if (out_inst !== '0 || out_pc !== '0) $display("FAIL empty_zero: got %h/%h expected 0/0", out_inst, out_pc); else passed++;
    end else if (out_ready && !redirect) begin
      total++;
      n_pop++;
      if (exp_q.size() == 0) $display("FAIL pop_order: got %h/%h expected no output", out_inst, out_pc);
      else begin
        e = exp_q.pop_front();
        if ({out_inst, out_pc} !== e) $display("FAIL pop_order: got %h/%h expected %h/%h", out_inst, out_pc, e[63:32], e[31:0]);
        else passed++;
      end
    end
    if (redirect) begin
      tgt = redirect_pc & ~32'h3;
      new_flow(tgt);
      watch = 1'b1;
      watch_addr = tgt;
      watch_cyc = pd.size() > 0 ? pd[pd.size()-1] + 1 : cyc + 1;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic release_reset();
    pa.delete(); pd.delete();
    watch = 1'b0; imem_valid = 1'b0; imem_rdata = '0; redirect = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    new_flow(RST_PC);
    cyc = 0;
  endtask

  task automatic apply_reset();
    rst = 1'b0; out_ready = 1'b0; redirect = 1'b0; imem_valid = 1'b0;
    @(negedge clk);
    release_reset();
  endtask

  task automatic test_reset();
    rst = 1'b0; imem_valid = 1'b0; redirect = 1'b0; out_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    #1;
    total += 4;
    if (imem_req !== 1'b0) $display("FAIL reset_req: got %b expected 0", imem_req); else passed++;
    if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", out_valid); else passed++;
    if (out_inst !== '0) $display("FAIL reset_inst: got %h expected 0", out_inst); else passed++;
    if (out_pc !== '0) $display("FAIL reset_pc: got %h expected 0", out_pc); else passed++;
    release_reset();
  endtask

  task automatic test_stream();
    int nv = 0;
    apply_reset();
    lat = 1; out_ready = 1'b1;
    cycle();
    total += 3;
    if (req_now !== 1'b1) $display("FAIL first_req: got %b expected 1", req_now); else passed++;
    if (addr_now !== RST_PC) $display("FAIL first_addr: got %h expected %h", addr_now, RST_PC); else passed++;
    cycle();
    if (vld_now !== BYP) $display("FAIL first_latency: got %b expected %b", vld_now, BYP); else passed++;
    cycle();
    total++;
    if (vld_now !== 1'b1) $display("FAIL second_latency: got %b expected 1", vld_now); else passed++;
    repeat (8) begin cycle(); nv += int'(vld_now); end
    total++;
    if (nv !== 8) $display("FAIL throughput: got %0d expected 8", nv); else passed++;
  endtask

  task automatic test_backpressure();
    int n0;
    bit found = 1'b0;
    apply_reset();
    lat = 1; out_ready = 1'b0;
    n0 = n_req;
    repeat (10) cycle();
    total += 4;
    if (n_req - n0 !== DEPTH) $display("FAIL full_reqs: got %0d expected %0d", n_req - n0, DEPTH); else passed++;
    if (req_now !== 1'b0) $display("FAIL full_stall: got %b expected 0", req_now); else passed++;
    if (vld_now !== 1'b1) $display("FAIL full_valid: got %b expected 1", vld_now); else passed++;
    out_ready = 1'b1;
    for (int i = 0; i < 4 && !found; i++) begin
      cycle();
      found = req_now;
    end
    if (!found || addr_now !== 32'h10) $display("FAIL resume_after_full: got %b/%h expected 1/00000010", found, addr_now); else passed++;
    repeat (12) cycle();
  endtask

  task automatic test_redirect();
    bit seen = 1'b0;
    apply_reset();
    lat = 3; out_ready = 1'b1;
    repeat (6) cycle();
    redirect = 1'b1; redirect_pc = 32'h40;
    cycle();
    redirect = 1'b0;
    for (int i = 0; i < 20 && (watch || !seen); i++) begin
      cycle();
      if (vld_now && !seen) begin
        seen = 1'b1;
        total++;
        if (pc_now !== 32'h44) $display("FAIL redirect_first_pc: got %h expected 00000044", pc_now); else passed++;
      end
    end
    total++;
    if (watch || !seen) $display("FAIL redirect_timeout: got watch=%b seen=%b expected 0/1", watch, seen); else passed++;
    repeat (8) cycle();
  endtask

  task automatic test_redirect_valid();
    apply_reset();
    lat = 2; out_ready = 1'b1;
    repeat (6) cycle();
    redirect = 1'b1; redirect_pc = 32'h43;
    cycle();
    redirect = 1'b0;
    cycle();
    total++;
    if (vld_now !== 1'b0) $display("FAIL redirect_flush: got %b expected 0", vld_now); else passed++;
    for (int i = 0; i < 10 && watch; i++) cycle();
    total++;
    if (watch) $display("FAIL redirect_valid_timeout: got 1 expected 0"); else passed++;
    repeat (8) cycle();
  endtask

  task automatic test_async_reset();
    apply_reset();
    lat = 1; out_ready = 1'b0;
    repeat (8) cycle();
    #2 rst = 1'b0;
    #1;
    total += 3;
    if (out_valid !== 1'b0) $display("FAIL async_valid: got %b expected 0", out_valid); else passed++;
    if (imem_req !== 1'b0) $display("FAIL async_req: got %b expected 0", imem_req); else passed++;
    if (out_pc !== '0) $display("FAIL async_pc: got %h expected 0", out_pc); else passed++;
    release_reset();
    lat = 4; out_ready = 1'b1;
    repeat (6) cycle();
    redirect = 1'b1; redirect_pc = 32'h80;
    cycle();
    redirect = 1'b0;
    cycle();
    #2 rst = 1'b0;
    #1;
    total += 2;
    if (out_valid !== 1'b0) $display("FAIL drain_reset_valid: got %b expected 0", out_valid); else passed++;
    if (imem_req !== 1'b0) $display("FAIL drain_reset_req: got %b expected 0", imem_req); else passed++;
    release_reset();
    cycle();
    total++;
    if (req_now !== 1'b1 || addr_now !== RST_PC) $display("FAIL post_reset_addr: got %b/%h expected 1/%h", req_now, addr_now, RST_PC); else passed++;
    repeat (12) cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_valid();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
